// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALUOp encodings, control-bit positions, ALU_Control codes
// and the ID/EX payload width.
package cpu_pkg;

    localparam logic [1:0] ALUOP_MEM    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

    // Bit positions inside the 6-bit control bundle {Branch, MemRead, MemWrite, MemtoReg, ALUSrc, RegWrite}
    localparam int CTRL_BRANCH   = 5;
    localparam int CTRL_MEMREAD  = 4;
    localparam int CTRL_MEMWRITE = 3;
    localparam int CTRL_MEMTOREG = 2;
    localparam int CTRL_ALUSRC   = 1;
    localparam int CTRL_REGWRITE = 0;

    localparam logic [2:0] ALUCTRL_ADD = 3'b001;
    localparam logic [2:0] ALUCTRL_SUB = 3'b010;

    localparam int CTRL_W  = 6;
    localparam int FUNCT_W = 10;
    localparam int ALUOP_W = 2;

    // pc, rs1, rs2, imm + three register addresses + funct + alu_op + ctrl
    function automatic int payload_width(input int xlen, input int reg_aw);
        return 4 * xlen + 3 * reg_aw + FUNCT_W + ALUOP_W + CTRL_W;
    endfunction

    localparam int PAYLOAD_W = 4 * 32 + 3 * 5 + FUNCT_W + ALUOP_W + CTRL_W;

endpackage

// File: rtl/skid_buffer.sv
// Generic two-entry valid/ready buffer with flush. Ready is a registered signal
// (no combinational path from out_ready_i), the skid entry absorbs the extra beat.
module skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o
);

    logic             main_valid;
    logic             skid_valid;
    logic [WIDTH-1:0] main_data;
    logic [WIDTH-1:0] skid_data;

    logic accept;
    logic main_free;

    assign accept    = in_valid_i & ~skid_valid;
    assign main_free = ~main_valid | out_ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_data  <= '0;
            skid_data  <= '0;
        end else if (flush_i) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (main_free) begin
            // Skid always refills main first so ordering stays FIFO; no accept happens then.
            if (skid_valid) begin
                main_valid <= 1'b1;
                main_data  <= skid_data;
                skid_valid <= 1'b0;
            end else begin
                main_valid <= accept;
                if (accept) begin
                    main_data <= in_data_i;
                end
            end
        end else if (accept) begin
            skid_valid <= 1'b1;
            skid_data  <= in_data_i;
        end
    end

    assign in_ready_o  = ~skid_valid;
    assign out_valid_o = main_valid;
    assign out_data_o  = main_data;

endmodule

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register: packs decoded fields into a skid buffer and masks the
// control-carrying outputs to a harmless ADD bubble whenever no instruction is held.
module id_ex_stage
    import cpu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [XLEN-1:0]   in_pc_i,
    input  logic [XLEN-1:0]   in_rs1_data_i,
    input  logic [XLEN-1:0]   in_rs2_data_i,
    input  logic [XLEN-1:0]   in_imm_i,
    input  logic [REG_AW-1:0] in_rs1_addr_i,
    input  logic [REG_AW-1:0] in_rs2_addr_i,
    input  logic [REG_AW-1:0] in_rd_addr_i,
    input  logic [9:0]        in_funct_i,
    input  logic [1:0]        in_alu_op_i,
    input  logic [5:0]        in_ctrl_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [XLEN-1:0]   out_pc_o,
    output logic [XLEN-1:0]   out_rs1_data_o,
    output logic [XLEN-1:0]   out_rs2_data_o,
    output logic [XLEN-1:0]   out_imm_o,
    output logic [REG_AW-1:0] out_rs1_addr_o,
    output logic [REG_AW-1:0] out_rs2_addr_o,
    output logic [REG_AW-1:0] out_rd_addr_o,
    output logic [9:0]        out_funct_o,
    output logic [1:0]        out_alu_op_o,
    output logic [5:0]        out_ctrl_o
);

    localparam int PW = payload_width(XLEN, REG_AW);

    logic [PW-1:0] in_payload;
    logic [PW-1:0] out_payload;

    logic [FUNCT_W-1:0] held_funct;
    logic [ALUOP_W-1:0] held_alu_op;
    logic [CTRL_W-1:0]  held_ctrl;

    assign in_payload = {in_pc_i, in_rs1_data_i, in_rs2_data_i, in_imm_i,
                         in_rs1_addr_i, in_rs2_addr_i, in_rd_addr_i,
                         in_funct_i, in_alu_op_i, in_ctrl_i};

    skid_buffer #(
        .WIDTH (PW)
    ) u_skid (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_payload),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_payload)
    );

    assign {out_pc_o, out_rs1_data_o, out_rs2_data_o, out_imm_o,
            out_rs1_addr_o, out_rs2_addr_o, out_rd_addr_o,
            held_funct, held_alu_op, held_ctrl} = out_payload;

    // Bubble: ALU_Control sees ALUOp=00 (ADD) and no side-effecting control bits.
    assign out_funct_o  = out_valid_o ? held_funct  : '0;
    assign out_alu_op_o = out_valid_o ? held_alu_op : ALUOP_MEM;
    assign out_ctrl_o   = out_valid_o ? held_ctrl   : '0;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed and randomized checks of the ID/EX skid-buffer stage against a queue model.
module tb_id_ex_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [4:0]  rd;
        logic [9:0]  funct;
        logic [1:0]  op;
        logic [5:0]  ctrl;
    } pl_t;

    logic        clk;
    logic        rst_i;
    logic        flush_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] in_pc_i, in_rs1_data_i, in_rs2_data_i, in_imm_i;
    logic [4:0]  in_rs1_addr_i, in_rs2_addr_i, in_rd_addr_i;
    logic [9:0]  in_funct_i;
    logic [1:0]  in_alu_op_i;
    logic [5:0]  in_ctrl_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] out_pc_o, out_rs1_data_o, out_rs2_data_o, out_imm_o;
    logic [4:0]  out_rs1_addr_o, out_rs2_addr_o, out_rd_addr_o;
    logic [9:0]  out_funct_o;
    logic [1:0]  out_alu_op_o;
    logic [5:0]  out_ctrl_o;

    int checks = 0;
    int errors = 0;

    id_ex_stage dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .flush_i        (flush_i),
        .in_valid_i     (in_valid_i),
        .in_ready_o     (in_ready_o),
        .in_pc_i        (in_pc_i),
        .in_rs1_data_i  (in_rs1_data_i),
        .in_rs2_data_i  (in_rs2_data_i),
        .in_imm_i       (in_imm_i),
        .in_rs1_addr_i  (in_rs1_addr_i),
        .in_rs2_addr_i  (in_rs2_addr_i),
        .in_rd_addr_i   (in_rd_addr_i),
        .in_funct_i     (in_funct_i),
        .in_alu_op_i    (in_alu_op_i),
        .in_ctrl_i      (in_ctrl_i),
        .out_valid_o    (out_valid_o),
        .out_ready_i    (out_ready_i),
        .out_pc_o       (out_pc_o),
        .out_rs1_data_o (out_rs1_data_o),
        .out_rs2_data_o (out_rs2_data_o),
        .out_imm_o      (out_imm_o),
        .out_rs1_addr_o (out_rs1_addr_o),
        .out_rs2_addr_o (out_rs2_addr_o),
        .out_rd_addr_o  (out_rd_addr_o),
        .out_funct_o    (out_funct_o),
        .out_alu_op_o   (out_alu_op_o),
        .out_ctrl_o     (out_ctrl_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic v, input pl_t p);
        in_valid_i    = v;
        in_pc_i       = p.pc;
        in_rs1_data_i = p.rs1;
        in_rs2_data_i = p.rs2;
        in_imm_i      = p.imm;
        in_rs1_addr_i = p.a1;
        in_rs2_addr_i = p.a2;
        in_rd_addr_i  = p.rd;
        in_funct_i    = p.funct;
        in_alu_op_i   = p.op;
        in_ctrl_i     = p.ctrl;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic pl_t mk(input logic [31:0] pc, input logic [9:0] f,
                               input logic [1:0] op, input logic [5:0] c);
        pl_t p;
        p.pc = pc; p.rs1 = pc ^ 32'h1111_0000; p.rs2 = pc ^ 32'h0000_2222;
        p.imm = pc + 32'd4; p.a1 = pc[6:2]; p.a2 = pc[7:3]; p.rd = pc[8:4];
        p.funct = f; p.op = op; p.ctrl = c;
        return p;
    endfunction

    function automatic pl_t observed();
        pl_t p;
        p = {out_pc_o, out_rs1_data_o, out_rs2_data_o, out_imm_o,
             out_rs1_addr_o, out_rs2_addr_o, out_rd_addr_o,
             out_funct_o, out_alu_op_o, out_ctrl_o};
        return p;
    endfunction

    task automatic test_reset();
        rst_i = 1'b1; flush_i = 1'b0; out_ready_i = 1'b0;
        drive(1'b0, '0);
        tick(); tick();
        rst_i = 1'b0;
        tick();
        checks++;
        if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1 || out_alu_op_o !== 2'b00 ||
            out_ctrl_o !== 6'h00 || out_pc_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: valid=%b ready=%b op=%b ctrl=%h pc=%h, want 0 1 00 00 00000000",
                     out_valid_o, in_ready_o, out_alu_op_o, out_ctrl_o, out_pc_o);
        end
        $display("reset: valid=%b ready=%b", out_valid_o, in_ready_o);
    endtask

    task automatic test_streaming();
        pl_t add_i, sub_i;
        add_i = mk(32'h40, 10'b0000000_000, 2'b10, 6'b000001);
        sub_i = mk(32'h44, 10'b0100000_000, 2'b10, 6'b000001);
        out_ready_i = 1'b1;
        drive(1'b1, add_i);
        tick();
        checks++;
        if (out_valid_o !== 1'b1 || observed() !== add_i || in_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL stream_add: valid=%b ready=%b out=%h want=%h", out_valid_o, in_ready_o, observed(), add_i);
        end
        $display("stream: ADD out pc=%h funct=%b", out_pc_o, out_funct_o);
        drive(1'b1, sub_i);
        tick();
        checks++;
        if (out_valid_o !== 1'b1 || observed() !== sub_i || in_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL stream_sub: valid=%b ready=%b out=%h want=%h", out_valid_o, in_ready_o, observed(), sub_i);
        end
        $display("stream: SUB out pc=%h funct=%b", out_pc_o, out_funct_o);
        drive(1'b0, '0);
        tick();
        checks++;
        if (out_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL stream_drain: valid=%b want 0", out_valid_o);
        end
    endtask

    task automatic test_backpressure();
        pl_t i1, i2;
        i1 = mk(32'h100, 10'b0000000_111, 2'b10, 6'b000001);
        i2 = mk(32'h104, 10'b0000000_110, 2'b11, 6'b000011);
        out_ready_i = 1'b0;
        drive(1'b1, i1);
        tick();
        checks++;
        if (observed() !== i1 || in_ready_o !== 1'b1 || out_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL bp_first: out=%h ready=%b want=%h ready=1", observed(), in_ready_o, i1);
        end
        drive(1'b1, i2);
        tick();
        checks++;
        if (observed() !== i1 || in_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL bp_stall_hold: out=%h ready=%b want=%h ready=0", observed(), in_ready_o, i1);
        end
        $display("backpressure: held pc=%h ready=%b", out_pc_o, in_ready_o);
        drive(1'b0, '0);
        out_ready_i = 1'b1;
        tick();
        checks++;
        if (observed() !== i2 || in_ready_o !== 1'b1 || out_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL bp_second: out=%h ready=%b want=%h ready=1", observed(), in_ready_o, i2);
        end
        $display("backpressure: released pc=%h", out_pc_o);
        tick();
        checks++;
        if (out_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL bp_empty: valid=%b want 0", out_valid_o);
        end
    endtask

    task automatic fill_both();
        out_ready_i = 1'b0;
        drive(1'b1, mk(32'h300, 10'h155, 2'b10, 6'b000001));
        tick();
        drive(1'b1, mk(32'h304, 10'h0AA, 2'b11, 6'b010111));
        tick();
        drive(1'b0, '0);
    endtask

    task automatic test_reset_midstream();
        fill_both();
        checks++;
        if (in_ready_o !== 1'b0 || out_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL mid_fill: ready=%b valid=%b want 0 1", in_ready_o, out_valid_o);
        end
        #2 rst_i = 1'b1;
        #1;
        checks++;
        if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1 || out_alu_op_o !== 2'b00 || out_ctrl_o !== 6'h00) begin
            errors++;
            $display("FAIL async_reset: valid=%b ready=%b op=%b ctrl=%h want 0 1 00 00",
                     out_valid_o, in_ready_o, out_alu_op_o, out_ctrl_o);
        end
        $display("async reset mid-stream: valid=%b ready=%b", out_valid_o, in_ready_o);
        @(negedge clk);
        rst_i = 1'b0;
        tick();
    endtask

    task automatic test_flush();
        fill_both();
        flush_i = 1'b1;
        out_ready_i = 1'b1;
        drive(1'b1, mk(32'h200, 10'b0000000_000, 2'b01, 6'b100000));
        tick();
        flush_i = 1'b0;
        drive(1'b0, '0);
        checks++;
        if (out_valid_o !== 1'b0 || out_ctrl_o !== 6'h00 || in_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL flush_clear: valid=%b ctrl=%h ready=%b want 0 00 1", out_valid_o, out_ctrl_o, in_ready_o);
        end
        tick();
        checks++;
        if (out_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_no_i3: valid=%b pc=%h want valid 0", out_valid_o, out_pc_o);
        end
        $display("flush: valid=%b ctrl=%h", out_valid_o, out_ctrl_o);
    endtask

    task automatic test_bubble();
        out_ready_i = 1'b1;
        drive(1'b0, mk(32'h500, 10'h3FF, 2'b11, 6'h3F));
        tick();
        checks++;
        if (out_valid_o !== 1'b0 || out_alu_op_o !== 2'b00 || out_ctrl_o !== 6'h00 || out_funct_o !== 10'h000) begin
            errors++;
            $display("FAIL bubble: valid=%b op=%b ctrl=%h funct=%h want 0 00 00 000",
                     out_valid_o, out_alu_op_o, out_ctrl_o, out_funct_o);
        end
        $display("bubble: op=%b ctrl=%h", out_alu_op_o, out_ctrl_o);
    endtask

    task automatic test_random();
        pl_t q[$];
        pl_t p;
        logic v, r, f;
        int xfers = 0;
        q.delete();
        for (int cyc = 0; cyc < 10000; cyc++) begin
            checks++;
            if (out_valid_o !== (q.size() > 0) || in_ready_o !== (q.size() < 2)) begin
                errors++;
                $display("FAIL rand_flags cyc %0d: valid=%b ready=%b model_count=%0d",
                         cyc, out_valid_o, in_ready_o, q.size());
            end
            if (q.size() > 0) begin
                checks++;
                if (observed() !== q[0]) begin
                    errors++;
                    $display("FAIL rand_data cyc %0d: out=%h want=%h", cyc, observed(), q[0]);
                end
            end else begin
                checks++;
                if (out_alu_op_o !== 2'b00 || out_ctrl_o !== 6'h00 || out_funct_o !== 10'h000) begin
                    errors++;
                    $display("FAIL rand_bubble cyc %0d: op=%b ctrl=%h funct=%h", cyc, out_alu_op_o, out_ctrl_o, out_funct_o);
                end
            end
            v = ($urandom_range(0, 9) < 6);
            r = ($urandom_range(0, 9) < 6);
            f = ($urandom_range(0, 99) < 2);
            p = {$urandom, $urandom, $urandom, $urandom, 5'($urandom), 5'($urandom),
                 5'($urandom), 10'($urandom), 2'($urandom), 6'($urandom)};
            drive(v, p);
            out_ready_i = r;
            flush_i = f;
            if (f) begin
                q.delete();
            end else begin
                if (out_valid_o && r) begin
                    void'(q.pop_front());
                    xfers++;
                end
                if (v && in_ready_o) q.push_back(p);
            end
            tick();
        end
        flush_i = 1'b0;
        drive(1'b0, '0);
        $display("random: 10000 cycles, %0d output transfers", xfers);
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_reset_midstream();
        test_flush();
        test_bubble();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
